sfp_add_arbiter: RTL
====================

// Module: sfp_add_arbiter
// PURPOSE
// - Shares one signed fixed-point adder datapath (sfp_add, Q IW.QW) between N_REQ requesters.
// - Round-robin grant, one operation per cycle; per-request clip/wrap mode.
// - Registered, tagged result returned through a single-entry response buffer with backpressure.
// - Sits between the shading/intersection units and the shared fp_core adder.
// PARAMETERS
// - N_REQ  4   number of requesters (>=2)
// - IW     16  integer bits of operands/result
// - QW     16  fractional bits; W = IW+QW = 32
// PORTS
// - clk          in   1            clock; all state on rising edge
// - rst          in   1            synchronous, active-high reset
// - req_valid    in   N_REQ        requester i presents an operation
// - req_ready    out  N_REQ        one-hot; operation of requester i accepted this cycle
// - req_x        in   N_REQ x W    operand x per requester (two's complement Q IW.QW)
// - req_y        in   N_REQ x W    operand y per requester
// - req_clip     in   N_REQ        1 = saturate on overflow, 0 = wrap
// - rsp_valid    out  1            result buffer holds a result
// - rsp_ready    in   1            consumer takes result when rsp_valid & rsp_ready
// - rsp_id       out  $clog2(N_REQ) requester index of the result
// - rsp_val      out  W            sum (saturated or wrapped per captured req_clip)
// - rsp_clipping out  1            overflow occurred (set in both modes)
// BEHAVIOUR
// - Reset: rsp_valid=0, rsp_id=0, rsp_val=0, rsp_clipping=0, RR pointer=0; req_ready comb, 0 while rst.
// - can_accept = !rsp_valid | rsp_ready (buffer empty or drained this cycle).
// - Grant: first i with req_valid[i], scanning from pointer upward with wrap; req_ready[i]=grant[i] & can_accept.
// - On accept of i: pointer <= (i+1) mod N_REQ; buffer loads id, sum, clipping; rsp_valid<=1. Pointer unchanged without accept.
// - Latency: accept at cycle t -> rsp_valid at t+1. Throughput 1/cycle when rsp_ready held 1.
// - Drain without accept: rsp_valid<=0. Drain and accept in same cycle: buffer overwritten, rsp_valid stays 1.
// - rsp_* stable while rsp_valid & !rsp_ready. Requesters hold req_* stable until req_ready.
// - Arithmetic: x+y at W bits. Overflow = operands same sign, result sign differs.
//   clip=1 -> 0x7FFF_FFFF (pos) / 0x8000_0000 (neg); clip=0 -> low W bits. rsp_clipping = overflow.
// - No valid request or !can_accept: req_ready=0, no state change except drain.
// - Reset mid-operation: pending result discarded; no response for an in-flight accept.
// CONFIGURATION
// - SFP_ADD_ARB_STATS_EN defined: adds output stat_clip_cnt [N_REQ x 16].
//   Per-requester saturating count (stops at 0xFFFF) of accepted ops with overflow. Reset to 0.
//   Increments at the accept cycle.
// - Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
// - Package sfp_arb_pkg holds:
//   - W constant;
//   - req_id_t = logic [$clog2(N_REQ)-1:0];
//   - rsp_t struct {id, val, clipping} for the buffer register.
// - Sub-module sfp_rr_arb: pointer register plus masked priority encoder. Outputs grant one-hot and grant index.
// - Datapath: two sfp_add instances (CLIP=1, CLIP=0), sfp_if ports, fed by the granted operand mux.
//   Granted req_clip selects between them. Clipping flags come from the selected instance.
// TESTING
// - Single op: req0 x=0x0001_8000, y=0x0002_4000, clip=1
//   -> next cycle rsp_valid=1, id=0, val=0x0003_C000, clipping=0.
// - Overflow: x=0x7FFF_0000, y=0x0002_0000
//   -> clip=1: val=0x7FFF_FFFF, clipping=1; clip=0: val=0x8001_0000, clipping=1.
// - Negative saturation: x=0x8000_0000, y=0xFFFF_0000, clip=1 -> val=0x8000_0000, clipping=1.
// - Fairness: all 4 req_valid held, rsp_ready=1
//   -> grants 0,1,2,3,0 on consecutive cycles, rsp_id follows one cycle later.
// - Backpressure: rsp_ready=0 with rsp_valid=1 -> req_ready=0, rsp_* frozen.
//   Raise rsp_ready -> same-cycle accept, rsp_valid stays 1.
// - Reset mid-flight: rst during accept cycle -> next cycle rsp_valid=0, pointer=0.
//   STATS_EN: 3 overflowing ops from req2 -> stat_clip_cnt[2]=3.

Source files
------------

// File: rtl/sfp_add_arbiter_pkg.sv
// ============================================================================
// Module : sfp_arb_pkg
// Brief  : Shared constants and types for the fixed-point adder arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sfp_arb_pkg;
    localparam int N_REQ = 4;
    localparam int IW    = 16;
    localparam int QW    = 16;
    localparam int W     = IW + QW;
    localparam int IDW   = $clog2(N_REQ);

    typedef logic [IDW-1:0] req_id_t;
    typedef logic [W-1:0]   word_t;

    typedef struct packed {
        req_id_t id;
        word_t   val;
        logic    clipping;
    } rsp_t;

    localparam word_t SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam word_t SAT_NEG = {1'b1, {(W-1){1'b0}}};
endpackage

`default_nettype wire

// File: rtl/sfp_add_arbiter_if.sv
// ============================================================================
// Module : sfp_add_arbiter_if / sfp_if
// Brief  : Requester/response bus of the arbiter, and the adder operand bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sfp_add_arbiter_if;
    import sfp_arb_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0][W-1:0] req_x;
    logic [N_REQ-1:0][W-1:0] req_y;
    logic [N_REQ-1:0]        req_clip;
    logic                    rsp_valid;
    logic                    rsp_ready;
    req_id_t                 rsp_id;
    word_t                   rsp_val;
    logic                    rsp_clipping;

    modport master (
        output req_valid, req_x, req_y, req_clip, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_val, rsp_clipping
    );
    modport slave (
        input  req_valid, req_x, req_y, req_clip, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_val, rsp_clipping
    );
endinterface

interface sfp_if;
    import sfp_arb_pkg::*;

    word_t x;
    word_t y;
    word_t sum;
    logic  ovf;

    modport user  (output x, y, input  sum, ovf);
    modport adder (input  x, y, output sum, ovf);
endinterface

`default_nettype wire

// File: rtl/sfp_add_arbiter_add.sv
// ============================================================================
// Module : sfp_add
// Brief  : Signed Q IW.QW adder; CLIP selects saturation or wrap on overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sfp_add
    import sfp_arb_pkg::*;
#(
    parameter bit CLIP = 1'b1
) (
    sfp_if.adder io
);
    word_t sum_w;
    logic  ovf_w;

    always_comb begin
        sum_w  = io.x + io.y;
        ovf_w  = (io.x[W-1] == io.y[W-1]) && (sum_w[W-1] != io.x[W-1]);
        io.ovf = ovf_w;
        io.sum = sum_w;
        // Saturation direction follows the operands' shared sign.
        if (CLIP && ovf_w) begin
            io.sum = io.x[W-1] ? SAT_NEG : SAT_POS;
        end
    end
endmodule

`default_nettype wire

// File: rtl/sfp_add_arbiter_rr_arb.sv
// ============================================================================
// Module : sfp_rr_arb
// Brief  : Round-robin pointer with masked priority encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sfp_rr_arb
    import sfp_arb_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [N_REQ-1:0] req_i,
    input  wire logic             adv_i,
    output logic      [N_REQ-1:0] grant_o,
    output req_id_t               idx_o,
    output logic                  any_o
);
    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_o && req_i[(int'(ptr_q) + k) % N_REQ]) begin
                any_o   = 1'b1;
                idx_o   = req_id_t'((int'(ptr_q) + k) % N_REQ);
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = req_id_t'((int'(idx_o) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/sfp_add_arbiter.sv
// ============================================================================
// Module : sfp_add_arbiter
// Brief  : Round-robin shared fixed-point adder with a one-entry response
//          buffer. Define SFP_ADD_ARB_STATS_EN for per-requester clip counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sfp_add_arbiter
    import sfp_arb_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   rst,
    sfp_add_arbiter_if.slave            bus
`ifdef SFP_ADD_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][15:0]      stat_clip_cnt
`endif
);
    logic             can_accept;
    logic             accept;
    logic             any_req;
    logic [N_REQ-1:0] grant;
    req_id_t          gidx;
    logic             sel_clip;
    logic             rsp_valid_q;
    rsp_t             rsp_q;
    rsp_t             rsp_d;

    sfp_if sat_if ();
    sfp_if wrap_if ();

    assign can_accept    = !rsp_valid_q || bus.rsp_ready;
    assign accept        = any_req && can_accept && !rst;
    assign bus.req_ready = grant & {N_REQ{accept}};

    sfp_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.req_valid),
        .adv_i   (accept),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (any_req)
    );

    assign sat_if.x  = bus.req_x[gidx];
    assign sat_if.y  = bus.req_y[gidx];
    assign wrap_if.x = bus.req_x[gidx];
    assign wrap_if.y = bus.req_y[gidx];
    assign sel_clip  = bus.req_clip[gidx];

    sfp_add #(.CLIP(1'b1)) u_add_sat  (.io(sat_if));
    sfp_add #(.CLIP(1'b0)) u_add_wrap (.io(wrap_if));

    always_comb begin
        rsp_d          = '0;
        rsp_d.id       = gidx;
        rsp_d.val      = sel_clip ? sat_if.sum : wrap_if.sum;
        rsp_d.clipping = sel_clip ? sat_if.ovf : wrap_if.ovf;
    end

    // A drain and a new accept in the same cycle simply overwrite the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_q.id;
    assign bus.rsp_val      = rsp_q.val;
    assign bus.rsp_clipping = rsp_q.clipping;

`ifdef SFP_ADD_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] clip_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_q <= '0;
        end else if (accept && rsp_d.clipping && (clip_cnt_q[gidx] != 16'hFFFF)) begin
            clip_cnt_q[gidx] <= clip_cnt_q[gidx] + 16'd1;
        end
    end

    assign stat_clip_cnt = clip_cnt_q;
`endif
endmodule

`default_nettype wire
